ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Runs the host side of the open-drain ps2_clock/ps2_data lines; top level drives each pad low when its *_oe=1, else 'z'.
//  rx_inhibit masks the receive path (PS2_Interface) while a frame is outbound.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clock-low hold before request-to-send (100 us @ 50 MHz)
//  START_TIMEOUT   750000   max cycles from clock release to first device falling edge (15 ms)
//  BIT_TIMEOUT     10000    max cycles between consecutive device falling edges (200 us)
// PORTS
//  clock        in   1  system clock, 50 MHz
//  resetn       in   1  asynchronous reset, active-low
//  tx_data      in   8  command byte, captured on accept
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready at a rising clock edge
//  tx_ready     out  1  1 only in IDLE
//  tx_done      out  1  1-cycle pulse: frame sent and ACK seen
//  tx_error     out  1  1-cycle pulse: frame aborted; err_code is valid in the same cycle
//  err_code     out  2  00 none, 01 start timeout, 10 bit timeout, 11 no ACK; held until next accept
//  rx_inhibit   out  1  1 in every state except IDLE
//  ps2_clk_in   in   1  raw ps2_clock pad value (asynchronous)
//  ps2_data_in  in   1  raw ps2_data pad value (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clock low
//  ps2_data_oe  out  1  1 = pull ps2_data low
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all *_oe=0 (lines released), tx_ready=1, tx_done=0, tx_error=0,
//    err_code=00, rx_inhibit=0, bit counter and timer = 0. Reset mid-frame releases both lines at once; no pulse.
//  Pads are sampled through a 2-flop synchronizer. fall = prev & ~cur on the synchronized clock (2-3 cycles latency).
//  Shift register sh[8:0] = {~^tx_data (odd parity), tx_data}, loaded on accept; bitcnt 0..10.
//  FSM:
//   IDLE:     on accept -> INHIBIT, timer=0, err_code=00. tx_valid while not ready is ignored (not queued).
//   INHIBIT:  clk_oe=1, data_oe=0; when timer==INHIBIT_CYCLES-1 -> REQ.
//   REQ:      one cycle clk_oe=1, data_oe=1 (start bit), then -> XFER with clk_oe=0, timer=0, bitcnt=0.
//   XFER:     data_oe held. On fall with bitcnt<9: data_oe=~sh[0], shift right, bitcnt++ (LSB first, then parity).
//             On fall with bitcnt==9: data_oe=0 (stop bit), bitcnt=10, -> ACK.
//             Timer resets on every fall. Before the first fall, timeout at START_TIMEOUT (code 01); after it, at BIT_TIMEOUT (code 10).
//   ACK:      on the next fall, sample synchronized data: 0 -> WAIT_IDLE; 1 -> ERR with code 11. BIT_TIMEOUT applies (code 10).
//   WAIT_IDLE: wait until synchronized clock==1 and data==1, then pulse tx_done -> IDLE. BIT_TIMEOUT applies (code 10).
//   ERR:      both *_oe=0, pulse tx_error, -> IDLE.
//  Data changes only just after a falling edge, so it is stable while clock is low. The device samples on the rising edge.
//  Timer: 20 bits, saturating. The comparison uses the timeout limit for the current state.
//  tx_ready rises the cycle after tx_done or tx_error. Back-to-back accept is then allowed.
//  Simultaneous fall and timeout in the same cycle: fall wins.
// STRUCTURE
//  ps2_pkg: state encoding, ERR_* codes, command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, ACK_BYTE=8'hFA).
//  Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detector, one instance per pad. The receiver reuses the same module.
//  The top level adds the tri-state assigns and ties rx_inhibit into the PS2_Interface enable.
// TESTING
//  Use a device BFM: clock period 80 us, samples on rising edges, drives ACK. Simulation parameters: INHIBIT=20, START=400, BIT=200.
//  1 Send 0xED -> bits LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1; BFM ACK low -> one tx_done pulse, err_code=00, lines released.
//  2 Send 0x00 -> parity bit 1. Send 0x01 -> parity bit 0. Check clk_oe is high for exactly INHIBIT cycles before data_oe.
//  3 BFM never clocks -> tx_error at START_TIMEOUT, err_code=01, both oe=0, tx_ready=1 the next cycle.
//  4 BFM stops after 5 falls -> tx_error after BIT_TIMEOUT, err_code=10.
//  5 BFM leaves data high at the ACK edge -> tx_error, err_code=11, no tx_done.
//  6 Assert resetn=0 mid-XFER (bit 4) -> *_oe=0 with no clock edge, no pulses; a new tx_valid after reset completes normally.
//  Also: tx_valid held through busy is not re-accepted; rx_inhibit=1 for the whole frame.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmitter:
//   - state_t        : transmitter FSM encoding (also exported for debug)
//   - ERR_*          : abort reason codes reported on err_code
//   - CMD_* / ACK_*  : common keyboard command bytes and the device ACK byte
//   - frame_payload  : builds the 9-bit {parity, data} shift-register image
// ---------------------------------------------------------------------------
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_XFER      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_START_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BIT_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_NO_ACK        = 2'b11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    localparam int TIMER_W = 20;

    // Odd parity: the parity bit makes the total count of ones in
    // data+parity odd, so it is the inverted XOR-reduction of the data.
    function automatic logic [8:0] frame_payload(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
//   Command-side handshake of the PS/2 host transmitter.
//   Handshake: a command is accepted on a rising clock edge where
//   tx_valid & tx_ready are both 1; tx_data is captured on that edge.
//   tx_valid seen while tx_ready is 0 is ignored, never queued. After
//   acceptance the requester watches for exactly one of tx_done or
//   tx_error (single-cycle pulses); err_code is valid with tx_error and
//   holds until the next accept.
//   Signals:
//     tx_data  [7:0]  command byte        (master -> slave)
//     tx_valid        request             (master -> slave)
//     tx_ready        idle / can accept   (slave  -> master)
//     tx_done         frame sent + ACKed  (slave  -> master)
//     tx_error        frame aborted       (slave  -> master)
//     err_code [1:0]  abort reason        (slave  -> master)
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_error, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_error, err_code
    );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_sync_edge
//   Two-flop synchronizer for one asynchronous PS/2 pad, followed by a
//   falling-edge detector on the synchronized level. Shared with the
//   receive path.
//   Ports:
//     clock, resetn : system clock, async active-low reset
//     pad           : raw pad value (asynchronous)
//     level         : synchronized pad value
//     fall          : 1 for one cycle after a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module ps2_host_tx_sync_edge (
    input  logic clock,
    input  logic resetn,
    input  logic pad,
    output logic level,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    // Reset to 1: an idle PS/2 line is pulled high, so no spurious fall
    // is reported when reset is released.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pad;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fall  = prev & ~sync;
endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the device
//   over the open-drain ps2_clock/ps2_data lines: holds clock low, issues
//   request-to-send (start bit), shifts data LSB first plus odd parity on
//   device-generated falling edges, releases data for the stop bit and
//   checks the device ACK. The pad wrapper drives each line low when its
//   *_oe is 1 and leaves it high-impedance otherwise.
//   Ports:
//     clock, resetn  : system clock, async active-low reset
//     bus            : command handshake (slave side of ps2_host_tx_if)
//     rx_inhibit     : 1 while a frame is outbound; masks the receiver
//     ps2_clk_in     : raw ps2_clock pad value
//     ps2_data_in    : raw ps2_data pad value
//     ps2_clk_oe     : 1 = pull ps2_clock low
//     ps2_data_oe    : 1 = pull ps2_data low
//     state_dbg      : current FSM state
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned BIT_TIMEOUT    = 10000
) (
    input  logic          clock,
    input  logic          resetn,
    ps2_host_tx_if.slave  bus,
    output logic          rx_inhibit,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe,
    output state_t        state_dbg
);
    // Terminal counts: the timer starts at 0 on entry, so a limit of N
    // cycles is reached when the timer shows N-1.
    localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(BIT_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    logic clk_s;
    logic clk_fall;
    logic data_s;
    logic data_fall_unused;

    ps2_host_tx_sync_edge u_clk_sync (
        .clock  (clock),
        .resetn (resetn),
        .pad    (ps2_clk_in),
        .level  (clk_s),
        .fall   (clk_fall)
    );

    ps2_host_tx_sync_edge u_data_sync (
        .clock  (clock),
        .resetn (resetn),
        .pad    (ps2_data_in),
        .level  (data_s),
        .fall   (data_fall_unused)
    );

    state_t               state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [3:0]           bitcnt, bitcnt_n;
    logic [8:0]           sh, sh_n;
    logic                 data_oe_q, data_oe_n;
    logic [1:0]           err_q, err_n;
    logic [TIMER_W-1:0]   limit_last;
    logic                 timed_out;
    logic                 done_c;
    logic                 error_c;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bitcnt    <= '0;
            sh        <= '0;
            data_oe_q <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bitcnt    <= bitcnt_n;
            sh        <= sh_n;
            data_oe_q <= data_oe_n;
            err_q     <= err_n;
        end
    end

    // Until the device produces its first falling edge (bitcnt still 0 in
    // XFER) it gets the long start allowance; afterwards every gap is
    // bounded by the per-bit limit.
    always_comb begin
        limit_last = BIT_LAST;
        if (state == ST_INHIBIT) begin
            limit_last = INH_LAST;
        end else if (state == ST_XFER && bitcnt == 4'd0) begin
            limit_last = START_LAST;
        end
        timed_out = (timer >= limit_last);
    end

    always_comb begin
        state_n    = state;
        timer_n    = (timer == TIMER_MAX) ? timer : timer + 1'b1;
        bitcnt_n   = bitcnt;
        sh_n       = sh;
        data_oe_n  = data_oe_q;
        err_n      = err_q;
        ps2_clk_oe = 1'b0;
        done_c     = 1'b0;
        error_c    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                timer_n   = '0;
                data_oe_n = 1'b0;
                if (bus.tx_valid) begin
                    state_n  = ST_INHIBIT;
                    err_n    = ERR_NONE;
                    sh_n     = frame_payload(bus.tx_data);
                    bitcnt_n = '0;
                end
            end

            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timed_out) begin
                    state_n   = ST_REQ;
                    data_oe_n = 1'b1;   // start bit
                end
            end

            ST_REQ: begin
                ps2_clk_oe = 1'b1;
                state_n    = ST_XFER;
                timer_n    = '0;
                bitcnt_n   = '0;
            end

            // Data only changes right after a device falling edge, so it is
            // stable for the device's rising-edge sample. A fall in the same
            // cycle as a timeout takes priority.
            ST_XFER: begin
                if (clk_fall) begin
                    timer_n = '0;
                    if (bitcnt < 4'd9) begin
                        data_oe_n = ~sh[0];
                        sh_n      = {1'b0, sh[8:1]};
                        bitcnt_n  = bitcnt + 4'd1;
                    end else begin
                        data_oe_n = 1'b0;       // stop bit: release
                        bitcnt_n  = 4'd10;
                        state_n   = ST_ACK;
                    end
                end else if (timed_out) begin
                    state_n   = ST_ERR;
                    data_oe_n = 1'b0;
                    err_n     = (bitcnt == 4'd0) ? ERR_START_TIMEOUT : ERR_BIT_TIMEOUT;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    timer_n = '0;
                    if (!data_s) begin
                        state_n = ST_WAIT_IDLE;
                    end else begin
                        state_n = ST_ERR;
                        err_n   = ERR_NO_ACK;
                    end
                end else if (timed_out) begin
                    state_n = ST_ERR;
                    err_n   = ERR_BIT_TIMEOUT;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_c  = 1'b1;
                    state_n = ST_IDLE;
                end else if (timed_out) begin
                    state_n = ST_ERR;
                    err_n   = ERR_BIT_TIMEOUT;
                end
            end

            ST_ERR: begin
                error_c   = 1'b1;
                data_oe_n = 1'b0;
                state_n   = ST_IDLE;
            end

            default: begin
                state_n   = ST_IDLE;
                data_oe_n = 1'b0;
            end
        endcase
    end

    assign ps2_data_oe  = data_oe_q;
    assign rx_inhibit   = (state != ST_IDLE);
    assign bus.tx_ready = (state == ST_IDLE);
    assign bus.tx_done  = done_c;
    assign bus.tx_error = error_c;
    assign bus.err_code = err_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Bench for ps2_host_tx with a PS/2 device model on the open-drain lines.
//   The device clock is scaled to 40 system cycles per period so that the
//   reduced INHIBIT/START/BIT limits stay meaningful.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH   = 20;
    localparam int START = 400;
    localparam int BIT   = 200;
    localparam int HALF  = 20;

    // ---------------- clock / reset ----------------
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // ---------------- DUT and lines ----------------
    ps2_host_tx_if bus ();
    logic   rx_inhibit;
    logic   ps2_clk_oe;
    logic   ps2_data_oe;
    logic   ps2_clk_in;
    logic   ps2_data_in;
    state_t state_dbg;
    logic   dev_clk_low  = 1'b0;
    logic   dev_data_low = 1'b0;

    // Wired-AND of host and device open-drain drivers with pull-ups.
    assign ps2_clk_in  = !(ps2_clk_oe  || dev_clk_low);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (START),
        .BIT_TIMEOUT    (BIT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus.slave),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [10:0] exp_q[$];
    bit          busy = 1'b0;
    int          done_cycles = 0;
    int          err_cycles  = 0;
    int          inh_run  = 0;
    int          last_inh = 0;
    int          last_fall_cyc = 0;

    // Expected line frame {stop, parity, data LSB..MSB, start} from the
    // protocol rules: odd parity means parity=1 when the data has an even
    // number of ones.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Per-cycle compare against the transaction-level model: the bench's
    // own busy flag says whether a frame is in flight.
    always @(negedge clock) begin
        if (resetn) begin
            bit bad;
            bad = 1'b0;
            if (rx_inhibit !== !bus.tx_ready) bad = 1'b1;
            if (bus.tx_ready === 1'b1 && (ps2_clk_oe || ps2_data_oe)) bad = 1'b1;
            if (busy && !bus.tx_done && !bus.tx_error && (bus.tx_ready !== 1'b0 || rx_inhibit !== 1'b1)) bad = 1'b1;
            if (!busy && (bus.tx_done || bus.tx_error)) bad = 1'b1;
            if (bus.tx_done && bus.tx_error) bad = 1'b1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL cycle_check @%0d: busy=%0b ready=%0b inhibit=%0b clk_oe=%0b data_oe=%0b done=%0b error=%0b",
                         cyc, busy, bus.tx_ready, rx_inhibit, ps2_clk_oe, ps2_data_oe, bus.tx_done, bus.tx_error);
            end
            if (bus.tx_done)  done_cycles++;
            if (bus.tx_error) err_cycles++;
            if (bus.tx_done || bus.tx_error) busy = 1'b0;
            if (ps2_clk_oe && !ps2_data_oe) begin
                inh_run++;
            end else begin
                if (ps2_clk_oe && ps2_data_oe && inh_run != 0) last_inh = inh_run;
                inh_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b, input bit hold);
        int t;
        t = 0;
        @(negedge clock);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && t < 1000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 1000) begin
            check("accept_timeout", 32'(t), 32'(0));
            bus.tx_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            busy = 1'b1;
            exp_q.push_back(frame_model(b));
            if (!hold) bus.tx_valid = 1'b0;
        end
    endtask

    // Device model: waits for request-to-send, then produces n_falls clock
    // pulses, sampling data at the end of each low phase (the rising edge).
    // Pulse 11 is the ACK pulse; with ack_low the device pulls data low.
    task automatic bfm_run(input int n_falls, input bit ack_low,
                           output logic [10:0] bits, output bit ok);
        int t;
        bits = '0;
        ok   = 1'b0;
        t    = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 300) begin
            @(posedge clock);
            t++;
        end
        if (t >= 300) return;
        repeat (10) @(posedge clock);
        bits[0] = ps2_data_in;
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11 && ack_low) dev_data_low = 1'b1;
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(posedge clock);
            if (k <= 10) bits[k] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(posedge clock);
        end
        dev_data_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_pulse(input int limit, output bit done, output bit err,
                              output logic [1:0] code, output logic oe, output int at);
        done = 1'b0; err = 1'b0; code = '0; oe = 1'b0; at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (bus.tx_done || bus.tx_error) begin
                done = bus.tx_done;
                err  = bus.tx_error;
                code = bus.err_code;
                oe   = ps2_clk_oe | ps2_data_oe;
                at   = cyc;
                return;
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (bus.tx_ready !== 1'b1 && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (t >= 400) check({name, "_ready_timeout"}, 32'(t), 32'(0));
    endtask

    task automatic good_frame(input logic [7:0] b, input string name, output logic [10:0] got);
        int          d0, e0;
        bit          ok;
        logic [10:0] exp;
        d0 = done_cycles;
        e0 = err_cycles;
        send(b, 1'b0);
        bfm_run(11, 1'b1, got, ok);
        check({name, "_bfm_ok"}, 32'(ok), 32'(1));
        wait_ready(name);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h0;
        check({name, "_frame"}, 32'(got), 32'(exp));
        check({name, "_done_pulses"}, 32'(done_cycles - d0), 32'(1));
        check({name, "_err_pulses"},  32'(err_cycles - e0),  32'(0));
        check({name, "_err_code"},    32'(bus.err_code), 32'(ERR_NONE));
        check({name, "_lines_free"},  32'({ps2_clk_oe, ps2_data_oe}), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] got;
        bit          ok, pd, pe;
        logic [1:0]  code;
        logic        oe;
        int          at, c0, t, d0, e0;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready",    32'(bus.tx_ready), 32'(1));
        check("rst_oe",       32'({ps2_clk_oe, ps2_data_oe}), 32'(0));
        check("rst_pulses",   32'({bus.tx_done, bus.tx_error}), 32'(0));
        check("rst_err_code", 32'(bus.err_code), 32'(0));
        check("rst_inhibit",  32'(rx_inhibit), 32'(0));
        check("rst_state",    32'(state_dbg), 32'(ST_IDLE));
        resetn = 1'b1;
        repeat (5) @(negedge clock);

        // 1: set-LEDs command, literal line image 1,1,11101101,0
        good_frame(CMD_SET_LEDS, "ed", got);
        check("ed_literal", 32'(got), 32'(11'h7DA));
        check("ed_inhibit_len", 32'(last_inh), 32'(INH));

        // 2: parity corners
        good_frame(8'h00, "b00", got);
        check("b00_literal", 32'(got), 32'(11'h600));
        good_frame(8'h01, "b01", got);
        check("b01_literal", 32'(got), 32'(11'h402));
        check("b01_inhibit_len", 32'(last_inh), 32'(INH));

        // 3: device never clocks
        send(8'h55, 1'b0);
        t = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 100) begin
            @(negedge clock);
            t++;
        end
        c0 = cyc;
        wait_pulse(START + 100, pd, pe, code, oe, at);
        check("start_to_error", 32'(pe), 32'(1));
        check("start_to_no_done", 32'(pd), 32'(0));
        check("start_to_code", 32'(code), 32'(ERR_START_TIMEOUT));
        check("start_to_oe", 32'(oe), 32'(0));
        check_range("start_to_time", at - c0, START - 1, START + 2);
        @(negedge clock);
        check("start_to_ready_next", 32'(bus.tx_ready), 32'(1));
        if (exp_q.size() > 0) void'(exp_q.pop_front());

        // 4: device stops after five falls
        send(ACK_BYTE, 1'b0);
        fork
            bfm_run(5, 1'b0, got, ok);
            wait_pulse(START + BIT + 1500, pd, pe, code, oe, at);
        join
        check("bit_to_error", 32'(pe), 32'(1));
        check("bit_to_code", 32'(code), 32'(ERR_BIT_TIMEOUT));
        check_range("bit_to_time", at - last_fall_cyc, BIT, BIT + 6);
        wait_ready("bit_to");
        if (exp_q.size() > 0) void'(exp_q.pop_front());

        // 5: no ACK from device
        d0 = done_cycles;
        send(CMD_RESET, 1'b0);
        fork
            bfm_run(11, 1'b0, got, ok);
            wait_pulse(2000, pd, pe, code, oe, at);
        join
        check("noack_error", 32'(pe), 32'(1));
        check("noack_code", 32'(code), 32'(ERR_NO_ACK));
        check("noack_frame", 32'(got), 32'((exp_q.size() > 0) ? exp_q.pop_front() : 11'h0));
        wait_ready("noack");
        check("noack_no_done", 32'(done_cycles - d0), 32'(0));
        check("noack_code_held", 32'(bus.err_code), 32'(ERR_NO_ACK));

        // 6: reset in the middle of the data bits
        d0 = done_cycles;
        e0 = err_cycles;
        send(8'h00, 1'b0);
        bfm_run(4, 1'b0, got, ok);
        @(negedge clock);
        check("mid_data_oe", 32'(ps2_data_oe), 32'(1));
        #2;
        resetn = 1'b0;
        busy   = 1'b0;
        #1;
        check("mid_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'(0));
        check("mid_rst_ready", 32'(bus.tx_ready), 32'(1));
        check("mid_rst_pulses", 32'({bus.tx_done, bus.tx_error}), 32'(0));
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        check("mid_rst_no_pulse_cnt", 32'((done_cycles - d0) + (err_cycles - e0)), 32'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) @(negedge clock);
        good_frame(CMD_ENABLE, "after_rst", got);

        // 7: tx_valid held (with changing data) through the busy frame
        d0 = done_cycles;
        send(8'h3C, 1'b1);
        bus.tx_data = 8'hC3;
        fork
            bfm_run(11, 1'b1, got, ok);
            begin
                wait_pulse(3000, pd, pe, code, oe, at);
                bus.tx_valid = 1'b0;
            end
        join
        check("held_done", 32'(pd), 32'(1));
        check("held_frame", 32'(got), 32'((exp_q.size() > 0) ? exp_q.pop_front() : 11'h0));
        repeat (30) @(negedge clock);
        check("held_done_pulses", 32'(done_cycles - d0), 32'(1));
        check("held_idle_after", 32'({bus.tx_ready, ps2_clk_oe}), 32'(2'b10));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
